tug_game_ctrl: RTL and testbench

- Tug-of-war game controller clocked by the 500 Hz divided clock (2 ms period).
- Debounces the two player buttons and the referee button.
- Moves a one-hot LED "rope" position left or right on each player press.
- Detects win and foul conditions; drives the LED bar and winner flags to the display stage.

---
 rtl/tug_pkg.sv | 21 ++
 rtl/tug_debounce.sv | 42 ++++
 rtl/tug_game_ctrl.sv | 95 +++++++++
 tb/tb_tug_game_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/tug_pkg.sv
// Shared types and sizing helpers for the tug-of-war game controller.
package tug_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    WIN_L = 2'd2,
    WIN_R = 2'd3
  } state_t;

  // Centre LED index of an odd-length bar.
  function automatic int unsigned ctr_of(input int unsigned n);
    return (n - 1) / 2;
  endfunction

  // Bits needed to hold a rope position in [0, n-1].
  function automatic int unsigned pos_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tug_debounce.sv
// Button conditioner: 2-flop synchroniser, level debounce, rising-edge pulse.
module tug_debounce #(
  parameter int unsigned DB_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          differ_c;
  logic          accept_c;

  // New level is accepted once it has differed from the stable level long enough.
  assign differ_c = (sync2 != stable);
  assign accept_c = differ_c && (cnt == CW'(DB_CYCLES - 1));

  // Synchroniser, hold counter, stable level and press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (!differ_c || accept_c) cnt <= '0;
      else                       cnt <= cnt + CW'(1);
      if (accept_c) stable <= sync2;
      pulse <= accept_c && sync2;
    end
  end

endmodule

// File: rtl/tug_game_ctrl.sv
// Tug-of-war game controller: debounced buttons drive a one-hot LED rope.
module tug_game_ctrl
  import tug_pkg::*;
#(
  parameter int unsigned NUM_LEDS  = 9,
  parameter int unsigned DB_CYCLES = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pbl,
  input  logic                pbr,
  input  logic                rf,
  output logic [NUM_LEDS-1:0] leds,
  output logic                winl,
  output logic                winr
);

  localparam int unsigned   PW      = pos_width(NUM_LEDS);
  localparam int unsigned   CTR     = ctr_of(NUM_LEDS);
  localparam logic [PW-1:0] POS_CTR = PW'(CTR);
  localparam logic [PW-1:0] POS_MAX = PW'(NUM_LEDS - 1);
  localparam logic [PW-1:0] POS_MIN = '0;

  state_t        state;
  state_t        state_n;
  logic [PW-1:0] pos;
  logic [PW-1:0] pos_n;
  logic          pl;
  logic          pr;
  logic          prf;

  tug_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_l  (.clk(clk), .rst(rst), .din(pbl), .pulse(pl));
  tug_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r  (.clk(clk), .rst(rst), .din(pbr), .pulse(pr));
  tug_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_rf (.clk(clk), .rst(rst), .din(rf),  .pulse(prf));

  // Next state and rope position; the referee always takes priority over players.
  always_comb begin
    state_n = state;
    pos_n   = pos;
    case (state)
      IDLE: begin
        if (prf) begin
          state_n = PLAY;
          pos_n   = POS_CTR;
        end else if (pl && !pr) begin
          state_n = WIN_R;
          pos_n   = POS_MIN;
        end else if (pr && !pl) begin
          state_n = WIN_L;
          pos_n   = POS_MAX;
        end
      end
      PLAY: begin
        if (prf) begin
          state_n = IDLE;
          pos_n   = POS_CTR;
        end else if (pl && !pr) begin
          pos_n = pos + PW'(1);
          if (pos_n == POS_MAX) state_n = WIN_L;
        end else if (pr && !pl) begin
          pos_n = pos - PW'(1);
          if (pos_n == POS_MIN) state_n = WIN_R;
        end
      end
      WIN_L, WIN_R: begin
        if (prf) begin
          state_n = IDLE;
          pos_n   = POS_CTR;
        end
      end
      default: begin
        state_n = IDLE;
        pos_n   = POS_CTR;
      end
    endcase
  end

  // State, position and registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pos   <= POS_CTR;
      leds  <= NUM_LEDS'(1) << CTR;
      winl  <= 1'b0;
      winr  <= 1'b0;
    end else begin
      state <= state_n;
      pos   <= pos_n;
      leds  <= NUM_LEDS'(1) << pos_n;
      winl  <= (state_n == WIN_L);
      winr  <= (state_n == WIN_R);
    end
  end

endmodule

// File: tb/tb_tug_game_ctrl.sv
// Directed self-checking bench for tug_game_ctrl (NUM_LEDS=9, DB_CYCLES=5).
module tb_tug_game_ctrl;
  import tug_pkg::*;

  logic       clk;
  logic       rst;
  logic       pbl;
  logic       pbr;
  logic       rf;
  logic [8:0] leds;
  logic       winl;
  logic       winr;
  int         total;
  int         bad;

  tug_game_ctrl #(.NUM_LEDS(9), .DB_CYCLES(5)) u_dut (
    .clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr), .rf(rf),
    .leds(leds), .winl(winl), .winr(winr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, leaving the bench 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold the chosen buttons for hi cycles, then release for 10 cycles.
  task automatic press(input logic l, input logic r, input logic f, input int hi);
    pbl = l; pbr = r; rf = f;
    tick(hi);
    pbl = 1'b0; pbr = 1'b0; rf = 1'b0;
    tick(10);
  endtask

  task automatic test_reset;
    rst = 1'b1; pbl = 1'b0; pbr = 1'b0; rf = 1'b0;
    #12;
    total++; if (leds !== 9'b000010000) begin bad++; $display("FAIL reset_leds got=%b exp=%b", leds, 9'b000010000); end
    total++; if ({winl, winr} !== 2'b00) begin bad++; $display("FAIL reset_wins got=%b exp=%b", {winl, winr}, 2'b00); end
    total++; if (u_dut.state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", u_dut.state, IDLE); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_start;
    rf = 1'b1;
    tick(6);
    total++; if (u_dut.prf !== 1'b0) begin bad++; $display("FAIL start_prf_early got=%b exp=0", u_dut.prf); end
    tick(1);
    total++; if (u_dut.prf !== 1'b1) begin bad++; $display("FAIL start_prf_edge7 got=%b exp=1", u_dut.prf); end
    tick(1);
    total++; if (u_dut.prf !== 1'b0) begin bad++; $display("FAIL start_prf_width got=%b exp=0", u_dut.prf); end
    total++; if (u_dut.state !== PLAY) begin bad++; $display("FAIL start_state got=%0d exp=%0d", u_dut.state, PLAY); end
    total++; if (leds !== 9'b000010000) begin bad++; $display("FAIL start_leds got=%b exp=%b", leds, 9'b000010000); end
    total++; if ({winl, winr} !== 2'b00) begin bad++; $display("FAIL start_wins got=%b exp=%b", {winl, winr}, 2'b00); end
    tick(12);
    rf = 1'b0;
    tick(10);
  endtask

  task automatic test_walk_left;
    logic [8:0] exp_l [4];
    exp_l[0] = 9'b000100000; exp_l[1] = 9'b001000000;
    exp_l[2] = 9'b010000000; exp_l[3] = 9'b100000000;
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 1'b0, 1'b0, 10);
      total++; if (leds !== exp_l[i]) begin bad++; $display("FAIL walk_left_leds%0d got=%b exp=%b", i, leds, exp_l[i]); end
      total++; if (winl !== (i == 3)) begin bad++; $display("FAIL walk_left_winl%0d got=%b exp=%b", i, winl, (i == 3)); end
    end
    press(1'b0, 1'b1, 1'b0, 10);
    press(1'b0, 1'b1, 1'b0, 10);
    total++; if (leds !== 9'b100000000) begin bad++; $display("FAIL winl_hold_leds got=%b exp=%b", leds, 9'b100000000); end
    total++; if ({winl, winr} !== 2'b10) begin bad++; $display("FAIL winl_hold_wins got=%b exp=%b", {winl, winr}, 2'b10); end
    press(1'b0, 1'b0, 1'b1, 10);
    total++; if (u_dut.state !== IDLE) begin bad++; $display("FAIL winl_clear_state got=%0d exp=%0d", u_dut.state, IDLE); end
    total++; if (leds !== 9'b000010000) begin bad++; $display("FAIL winl_clear_leds got=%b exp=%b", leds, 9'b000010000); end
  endtask

  task automatic test_foul;
    press(1'b0, 1'b1, 1'b0, 10);
    total++; if (leds !== 9'b100000000) begin bad++; $display("FAIL foul_leds got=%b exp=%b", leds, 9'b100000000); end
    total++; if ({winl, winr} !== 2'b10) begin bad++; $display("FAIL foul_wins got=%b exp=%b", {winl, winr}, 2'b10); end
    press(1'b0, 1'b0, 1'b1, 10);
    total++; if (leds !== 9'b000010000) begin bad++; $display("FAIL foul_clear_leds got=%b exp=%b", leds, 9'b000010000); end
    total++; if ({winl, winr} !== 2'b00) begin bad++; $display("FAIL foul_clear_wins got=%b exp=%b", {winl, winr}, 2'b00); end
    press(1'b1, 1'b0, 1'b1, 10);
    total++; if (u_dut.state !== PLAY) begin bad++; $display("FAIL ref_with_player_state got=%0d exp=%0d", u_dut.state, PLAY); end
    total++; if (leds !== 9'b000010000) begin bad++; $display("FAIL ref_with_player_leds got=%b exp=%b", leds, 9'b000010000); end
  endtask

  task automatic test_bounce;
    pbl = 1'b1; tick(3);
    pbl = 1'b0; tick(3);
    pbl = 1'b1; tick(3);
    pbl = 1'b0; tick(10);
    total++; if (leds !== 9'b000010000) begin bad++; $display("FAIL bounce_leds got=%b exp=%b", leds, 9'b000010000); end
    total++; if (u_dut.state !== PLAY) begin bad++; $display("FAIL bounce_state got=%0d exp=%0d", u_dut.state, PLAY); end
  endtask

  task automatic test_simultaneous;
    pbl = 1'b1; pbr = 1'b1;
    tick(7);
    total++; if ({u_dut.pl, u_dut.pr} !== 2'b11) begin bad++; $display("FAIL simul_pulses got=%b exp=%b", {u_dut.pl, u_dut.pr}, 2'b11); end
    tick(3);
    pbl = 1'b0; pbr = 1'b0;
    tick(10);
    total++; if (leds !== 9'b000010000) begin bad++; $display("FAIL simul_play_leds got=%b exp=%b", leds, 9'b000010000); end
    total++; if (u_dut.state !== PLAY) begin bad++; $display("FAIL simul_play_state got=%0d exp=%0d", u_dut.state, PLAY); end
  endtask

  task automatic test_walk_right;
    logic [8:0] exp_r [4];
    press(1'b0, 1'b1, 1'b0, 10);
    press(1'b0, 1'b0, 1'b1, 10);
    total++; if (u_dut.state !== IDLE) begin bad++; $display("FAIL abort_state got=%0d exp=%0d", u_dut.state, IDLE); end
    total++; if (leds !== 9'b000010000) begin bad++; $display("FAIL abort_leds got=%b exp=%b", leds, 9'b000010000); end
    press(1'b1, 1'b1, 1'b0, 10);
    total++; if (u_dut.state !== IDLE) begin bad++; $display("FAIL simul_idle_state got=%0d exp=%0d", u_dut.state, IDLE); end
    total++; if ({winl, winr} !== 2'b00) begin bad++; $display("FAIL simul_idle_wins got=%b exp=%b", {winl, winr}, 2'b00); end
    press(1'b0, 1'b0, 1'b1, 10);
    exp_r[0] = 9'b000001000; exp_r[1] = 9'b000000100;
    exp_r[2] = 9'b000000010; exp_r[3] = 9'b000000001;
    for (int i = 0; i < 4; i++) begin
      press(1'b0, 1'b1, 1'b0, 10);
      total++; if (leds !== exp_r[i]) begin bad++; $display("FAIL walk_right_leds%0d got=%b exp=%b", i, leds, exp_r[i]); end
      total++; if (winr !== (i == 3)) begin bad++; $display("FAIL walk_right_winr%0d got=%b exp=%b", i, winr, (i == 3)); end
    end
    total++; if (winl !== 1'b0) begin bad++; $display("FAIL walk_right_winl got=%b exp=0", winl); end
    press(1'b0, 1'b0, 1'b1, 10);
    press(1'b0, 1'b0, 1'b1, 10);
  endtask

  task automatic test_async_reset;
    press(1'b1, 1'b0, 1'b0, 10);
    press(1'b1, 1'b0, 1'b0, 10);
    total++; if (leds !== 9'b001000000) begin bad++; $display("FAIL pre_reset_leds got=%b exp=%b", leds, 9'b001000000); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (leds !== 9'b000010000) begin bad++; $display("FAIL async_reset_leds got=%b exp=%b", leds, 9'b000010000); end
    total++; if ({winl, winr} !== 2'b00) begin bad++; $display("FAIL async_reset_wins got=%b exp=%b", {winl, winr}, 2'b00); end
    pbl = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tick(7);
    total++; if (winr !== 1'b0) begin bad++; $display("FAIL held_press_early got=%b exp=0", winr); end
    tick(1);
    total++; if ({winl, winr} !== 2'b01) begin bad++; $display("FAIL held_press_foul got=%b exp=%b", {winl, winr}, 2'b01); end
    total++; if (leds !== 9'b000000001) begin bad++; $display("FAIL held_press_leds got=%b exp=%b", leds, 9'b000000001); end
    pbl = 1'b0;
    tick(10);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_start;
    test_walk_left;
    test_foul;
    test_bounce;
    test_simultaneous;
    test_walk_right;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
